// File: rtl/serial_subtractor_if.sv
// rtl/serial_subtractor_if.sv - start/operand request and result bundle for the bit-serial subtractor
interface serial_subtractor_if #(
   parameter int WIDTH = 8
) ();
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow;

   modport master (
      output start, a, b,
      input  busy, done, diff, borrow
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, borrow
   );
endinterface

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a-b, LSB first, one full-subtractor cell with a registered borrow
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input logic             clk,
   input logic             rst,
   serial_subtractor_if.slave bus
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [1:0]       state;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] res;
   logic [WIDTH-1:0] diff_q;
   logic             br;
   logic             borrow_q;
   logic [CW-1:0]    cnt;
   logic             x;
   logic             y;
   logic             d;
   logic             br_n;

   always_comb begin
      x    = sa[0];
      y    = sb[0];
      d    = x ^ y ^ br;
      br_n = (~x & y) | (~(x ^ y) & br);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         sa       <= '0;
         sb       <= '0;
         res      <= '0;
         diff_q   <= '0;
         br       <= 1'b0;
         borrow_q <= 1'b0;
         cnt      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  sa    <= bus.a;
                  sb    <= bus.b;
                  br    <= 1'b0;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               res <= {d, res[WIDTH-1:1]};
               br  <= br_n;
               cnt <= cnt + CW'(1);
               // The visible result is loaded only here, so it holds through IDLE and the next RUN.
               if (cnt == LAST) begin
                  diff_q   <= {d, res[WIDTH-1:1]};
                  borrow_q <= br_n;
                  state    <= DONE;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy   = (state == RUN);
   assign bus.done   = (state == DONE);
   assign bus.diff   = diff_q;
   assign bus.borrow = borrow_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - scoreboard bench for serial_subtractor (WIDTH=8)
module tb_serial_subtractor;
   localparam int W = 8;

   logic clk;
   logic rst;
   int   total;
   int   bad;
   int   done_seen;
   logic [W:0] sbq[$];

   serial_subtractor_if #(.WIDTH(W)) bus ();

   serial_subtractor #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (!rst && bus.done === 1'b1) begin
         done_seen++;
         total++;
         if (sbq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_done: got diff=%0h borrow=%0b with nothing expected", bus.diff, bus.borrow);
         end else begin
            logic [W:0] e;
            e = sbq.pop_front();
            if ({bus.diff, bus.borrow} !== e) begin
               bad++;
               $display("FAIL result: got diff=%0h borrow=%0b expected diff=%0h borrow=%0b",
                        bus.diff, bus.borrow, e[W:1], e[0]);
            end
         end
      end
   end

   // Called just after a posedge; start is sampled at the next posedge.
   task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [W:0] exp);
      bus.a     = av;
      bus.b     = bv;
      bus.start = 1'b1;
      sbq.push_back(exp);
      @(posedge clk);
      #1;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input int target);
      int n;
      n = 0;
      while (done_seen < target && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (done_seen < target) begin
         total++;
         bad++;
         $display("FAIL wait_done: timeout got=%0d dones expected=%0d", done_seen, target);
      end
   endtask

   task automatic run_vec(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] ed, input logic eb);
      int t;
      t = done_seen + 1;
      @(posedge clk);
      #1;
      issue(av, bv, {ed, eb});
      wait_done(t);
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      done_seen = 0;
      rst       = 1'b1;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("reset_busy", 32'(bus.busy), 32'd0);
      check("reset_done", 32'(bus.done), 32'd0);
      check("reset_diff", 32'(bus.diff), 32'd0);
      check("reset_borrow", 32'(bus.borrow), 32'd0);

      // Basic subtract with latency profile
      @(posedge clk);
      #1;
      issue(8'h5A, 8'h23, {8'h37, 1'b0});
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         check($sformatf("lat_busy_%0d", k), 32'(bus.busy), 32'd1);
         check($sformatf("lat_nodone_%0d", k), 32'(bus.done), 32'd0);
      end
      @(negedge clk);
      check("lat_done9", 32'(bus.done), 32'd1);
      check("lat_busy9", 32'(bus.busy), 32'd0);

      // Hold for 20 idle clocks
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         check("hold_diff", 32'(bus.diff), 32'h37);
         check("hold_borrow", 32'(bus.borrow), 32'd0);
      end

      run_vec(8'h10, 8'h20, 8'hF0, 1'b1);
      run_vec(8'h00, 8'h01, 8'hFF, 1'b1);
      run_vec(8'h00, 8'h00, 8'h00, 1'b0);
      run_vec(8'hFF, 8'h00, 8'hFF, 1'b0);
      run_vec(8'hA5, 8'hA5, 8'h00, 1'b0);

      // Busy protection: second start during RUN must be ignored
      begin
         int t;
         t = done_seen + 1;
         @(posedge clk);
         #1;
         issue(8'h5A, 8'h23, {8'h37, 1'b0});
         repeat (2) @(posedge clk);
         #1;
         bus.a     = 8'h01;
         bus.b     = 8'h02;
         bus.start = 1'b1;
         @(posedge clk);
         #1;
         bus.start = 1'b0;
         wait_done(t);
         for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("no_second_busy", 32'(bus.busy), 32'd0);
         end
         check("one_done_only", 32'(done_seen), 32'(t));
         check("busy_hold_diff", 32'(bus.diff), 32'h37);
      end

      // Reset mid-operation
      begin
         int t;
         t = done_seen;
         @(posedge clk);
         #1;
         issue(8'h10, 8'h01, {8'h0F, 1'b0});
         @(posedge clk);
         #1;
         rst = 1'b1;
         @(posedge clk);
         #1;
         rst = 1'b0;
         sbq.delete();
         @(negedge clk);
         check("midrst_busy", 32'(bus.busy), 32'd0);
         check("midrst_done", 32'(bus.done), 32'd0);
         check("midrst_diff", 32'(bus.diff), 32'd0);
         check("midrst_borrow", 32'(bus.borrow), 32'd0);
         repeat (14) @(negedge clk);
         check("midrst_no_done", 32'(done_seen), 32'(t));
         run_vec(8'h5A, 8'h23, 8'h37, 1'b0);
      end

      // Back-to-back: start in the first IDLE cycle after done
      begin
         int t;
         t = done_seen + 1;
         @(posedge clk);
         #1;
         issue(8'h5A, 8'h23, {8'h37, 1'b0});
         wait_done(t);
         @(posedge clk);
         #1;
         issue(8'h03, 8'h05, {8'hFE, 1'b1});
         wait_done(t + 1);
      end

      // Random vectors with in-flight operand changes
      for (int i = 0; i < 1000; i++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         logic [W-1:0] rd;
         int t;
         ra = W'($urandom_range(0, 255));
         rb = W'($urandom_range(0, 255));
         rd = ra - rb;
         t  = done_seen + 1;
         @(posedge clk);
         #1;
         issue(ra, rb, {rd, (ra < rb)});
         bus.a = W'($urandom_range(0, 255));
         bus.b = W'($urandom_range(0, 255));
         wait_done(t);
      end

      repeat (3) @(negedge clk);
      check("queue_empty", 32'(sbq.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
